// File: rtl/rv32_regfile_mp.sv
// rtl/rv32_regfile_mp.sv - multi-read-port RV32 register file with busy scoreboard and clear sequencer
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rd_addr / rd_data   NUM_RD combinational read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   rd_busy             per-port scoreboard bit for the addressed register
//   wr_en/addr/data     single synchronous write port (writeback)
//   alloc_en/addr       marks a register busy when a producer issues
//   busy_vec            registered scoreboard
//   ready               registered, high once the post-reset clear has finished
module rv32_regfile_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     alloc_en,
   input  logic [AW-1:0]            alloc_addr,
   output logic [NUM_REGS-1:0]      busy_vec,
   output logic                     ready
);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
   localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : '0;

   state_t                state_q, state_d;
   logic [AW-1:0]         clr_idx_q, clr_idx_d;
   logic                  ready_q, ready_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   logic [XLEN-1:0]       mem_q [NUM_REGS];
   logic                  mem_we;
   logic [AW-1:0]         mem_waddr;
   logic [XLEN-1:0]       mem_wdata;

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      busy_d    = busy_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;

      if (state_q == S_CLEAR) begin
         // Sequencer owns the write port; external writes/allocs are ignored.
         mem_we    = 1'b1;
         mem_waddr = clr_idx_q;
         mem_wdata = '0;
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == LAST_IDX) begin
            state_d = S_READY;
            ready_d = 1'b1;
         end
      end else begin
         if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
            mem_we          = !((ZERO_REG != 0) && (wr_addr == '0));
         end
         // Applied after the write-clear so a same-address alloc wins.
         if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
         end
      end

      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= FIRST_IDX;
         ready_q   <= 1'b0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // Storage has no reset; the clear sequencer zeroes it after every rst.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[i*AW +: AW];

      always_comb begin
         rd_data[i*XLEN +: XLEN] = mem_q[a];
         rd_busy[i]              = busy_q[a];
         if (!ready_q) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
         end else if ((ZERO_REG != 0) && (a == '0)) begin
            rd_data[i*XLEN +: XLEN] = '0;
            rd_busy[i]              = 1'b0;
         end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
            rd_data[i*XLEN +: XLEN] = wr_data;
            rd_busy[i]              = 1'b0;
         end
      end
   end

   assign busy_vec = busy_q;
   assign ready    = ready_q;

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// tb/tb_rv32_regfile_mp.sv - scoreboard bench for rv32_regfile_mp (BYPASS=1 and BYPASS=0 instances)
module tb_rv32_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        alloc_en;
   logic [4:0]  alloc_addr;
   logic [31:0] busy_vec_b, busy_vec_n;
   logic        ready_b, ready_n;

   always #5 clk = ~clk;

   rv32_regfile_mp #(.BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b), .ready(ready_b)
   );

   rv32_regfile_mp #(.BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_n), .ready(ready_n)
   );

   typedef struct {
      logic        chk;
      logic [63:0] data_b;
      logic [1:0]  busy_b;
      logic [63:0] data_n;
      logic [1:0]  busy_n;
      logic [31:0] busy_vec;
      logic        ready;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 0;

   // Reference model: architectural contents, scoreboard and edges since reset.
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   int          m_cnt;
   bit          m_valid = 0;

   function automatic bit m_ready();
      return m_valid && (m_cnt >= 31);
   endfunction

   function automatic void m_read(input logic [4:0] a, input bit byp,
                                  output logic [31:0] d, output logic b);
      d = 32'h0;
      b = 1'b0;
      if (!m_ready() || a == 5'd0) return;
      if (byp && wr_en && wr_addr == a) begin
         d = wr_data;
         return;
      end
      d = m_regs[a];
      b = m_busy[a];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL no_expectation at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) begin
               check("ready_b", 64'(ready_b), 64'(e.ready));
               check("ready_n", 64'(ready_n), 64'(e.ready));
               check("busy_vec_b", 64'(busy_vec_b), 64'(e.busy_vec));
               check("busy_vec_n", 64'(busy_vec_n), 64'(e.busy_vec));
               check("rd_data_byp", rd_data_b, e.data_b);
               check("rd_busy_byp", 64'(rd_busy_b), 64'(e.busy_b));
               check("rd_data_nobyp", rd_data_n, e.data_n);
               check("rd_busy_nobyp", 64'(rd_busy_n), 64'(e.busy_n));
            end
         end
      end
   end

   // One clock cycle: drive, push expectation, take the edge, advance the model.
   task automatic cyc(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ae, input logic [4:0] aa, input logic [4:0] a0, input logic [4:0] a1);
      exp_t        e;
      logic [31:0] d;
      logic        b;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      alloc_en = ae; alloc_addr = aa; rd_addr = {a1, a0};
      e.chk = m_valid;
      e.ready = m_ready();
      e.busy_vec = m_ready() ? m_busy : 32'h0;
      m_read(a0, 1'b1, d, b); e.data_b[31:0] = d;  e.busy_b[0] = b;
      m_read(a1, 1'b1, d, b); e.data_b[63:32] = d; e.busy_b[1] = b;
      m_read(a0, 1'b0, d, b); e.data_n[31:0] = d;  e.busy_n[0] = b;
      m_read(a1, 1'b0, d, b); e.data_n[63:32] = d; e.busy_n[1] = b;
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         m_valid = 1;
         m_cnt = 0;
         m_busy = 32'h0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else if (!m_ready()) begin
         m_cnt++;
      end else begin
         if (we && wa != 5'd0) m_regs[wa] = wd;
         if (we) m_busy[wa] = 1'b0;
         if (ae && aa != 5'd0) m_busy[aa] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
      @(posedge clk);
      #1;
      mon_en = 1;

      // Clear after reset, with writes/allocs during clear (cycle 10) ignored.
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
      idle(9);
      cyc(1'b0, 1'b1, 5'd4, 32'h1111_2222, 1'b1, 5'd4, 5'd4, 5'd4);
      idle(22);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd31);

      // Write/read and x0.
      cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2);
      cyc(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd5, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);

      // Bypass on x7.
      cyc(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
      cyc(1'b0, 1'b1, 5'd7, 32'h1357_9BDF, 1'b0, 5'd0, 5'd7, 5'd6);

      // Scoreboard on x3; alloc x0 ignored.
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0);
      cyc(1'b0, 1'b1, 5'd3, 32'h3333_0000, 1'b0, 5'd0, 5'd3, 5'd7);
      cyc(1'b0, 1'b1, 5'd3, 32'h3333_1111, 1'b1, 5'd3, 5'd3, 5'd1);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);

      // Reset mid-operation with busy_vec=0x88 and x2=0x55.
      cyc(1'b0, 1'b1, 5'd2, 32'h0000_0055, 1'b1, 5'd7, 5'd2, 5'd3);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd7);
      cyc(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1, 5'd9, 5'd2, 5'd7);
      idle(31);
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd7);

      // Randomized traffic, addresses biased low to force collisions.
      for (int k = 0; k < 600; k++) begin
         logic [4:0] wa, aa, a0, a1;
         wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         aa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         a0 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 1) != 0) ? aa : 5'($urandom_range(0, 7));
         cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
             1'($urandom_range(0, 1)), aa, a0, a1);
      end

      @(negedge clk);
      mon_en = 0;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
